// File: rtl/sb_dsp_dma.sv
// Sound Blaster DSP port decode, command parser and paced 8-bit single-cycle DMA
// on ISA channel 1, producing a signed 16-bit PCM sample stream for the mixer.
`timescale 1ns/1ps
module sb_dsp_dma #(
  parameter int          CLKS_PER_US = 50,
  parameter logic [7:0]  TC_RESET    = 8'hA6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        io_wr,
  input  logic        io_rd,
  input  logic [9:0]  io_addr,
  input  logic [7:0]  io_wdata,
  output logic [7:0]  io_rdata,
  output logic        io_rhit,
  input  logic        dack_n,
  input  logic        dma_wr,
  input  logic [7:0]  dma_data,
  output logic        drq,
  output logic        irq,
  output logic [15:0] pcm_s16,
  output logic        pcm_stb
);

  localparam logic [9:0] ADDR_RESET = 10'h226;
  localparam logic [9:0] ADDR_READ  = 10'h22A;
  localparam logic [9:0] ADDR_CMD   = 10'h22C;
  localparam logic [9:0] ADDR_STAT  = 10'h22E;

  localparam logic [7:0] OP_DAC     = 8'h10;
  localparam logic [7:0] OP_DMA8    = 8'h14;
  localparam logic [7:0] OP_TC      = 8'h40;
  localparam logic [7:0] OP_PAUSE   = 8'hD0;
  localparam logic [7:0] OP_SPK_ON  = 8'hD1;
  localparam logic [7:0] OP_SPK_OFF = 8'hD3;
  localparam logic [7:0] OP_RESUME  = 8'hD4;
  localparam logic [7:0] OP_VERSION = 8'hE1;

  localparam logic [7:0] RESET_ACK  = 8'hAA;
  localparam logic [7:0] VER_MAJOR  = 8'h02;
  localparam logic [7:0] VER_MINOR  = 8'h01;

  typedef enum logic [1:0] {P_CMD, P_ARG1, P_ARG2} parse_t;
  typedef enum logic [1:0] {D_IDLE, D_WAIT, D_REQ, D_PAUSE} dma_t;

  parse_t      pstate;
  dma_t        dstate;
  logic [7:0]  op;
  logic [7:0]  arg_lo;
  logic [7:0]  tc;
  logic [7:0]  sample;
  logic        speaker;
  logic        rst_arm;
  logic [16:0] remaining;
  logic [15:0] counter;
  logic [15:0] period;
  logic [15:0] period_m1;
  logic        dack_m, dack_s;

  logic [7:0]  q_mem [2];
  logic [1:0]  q_cnt;
  logic [7:0]  q0_nxt, q1_nxt;
  logic [1:0]  cnt_nxt;

  logic wr_cmd, wr_rst, rd_data, rd_stat, soft_rst, accept;
  logic do_dac, do_tc, do_start, do_pause, do_resume, do_spk_on, do_spk_off, do_ver;
  logic [16:0] start_len;

  // NOTE: sequential state uses non-blocking <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dack_m <= 1'b1;
      dack_s <= 1'b1;
    end else begin
      dack_m <= dack_n;
      dack_s <= dack_m;
    end
  end

  assign wr_cmd   = io_wr && (io_addr == ADDR_CMD);
  assign wr_rst   = io_wr && (io_addr == ADDR_RESET);
  assign rd_data  = io_rd && (io_addr == ADDR_READ);
  assign rd_stat  = io_rd && (io_addr == ADDR_STAT);
  // Soft reset fires on the 0 write that follows a 1 write to the reset port.
  assign soft_rst = wr_rst && !io_wdata[0] && rst_arm;
  assign accept   = dma_wr && drq && !dack_s && !soft_rst;

  assign period    = 16'(CLKS_PER_US) * (16'd256 - {8'd0, tc});
  assign period_m1 = period - 16'd1;

  // NOTE: every signal driven here gets a default first, so no latch is inferred.
  always_comb begin
    do_dac     = 1'b0;
    do_tc      = 1'b0;
    do_start   = 1'b0;
    do_pause   = 1'b0;
    do_resume  = 1'b0;
    do_spk_on  = 1'b0;
    do_spk_off = 1'b0;
    do_ver     = 1'b0;
    start_len  = '0;
    if (wr_cmd) begin
      case (pstate)
        P_CMD: begin
          case (io_wdata)
            OP_PAUSE:   do_pause   = 1'b1;
            OP_RESUME:  do_resume  = 1'b1;
            OP_SPK_ON:  do_spk_on  = 1'b1;
            OP_SPK_OFF: do_spk_off = 1'b1;
            OP_VERSION: do_ver     = 1'b1;
            default: begin end
          endcase
        end
        P_ARG1: begin
          do_dac = (op == OP_DAC);
          do_tc  = (op == OP_TC);
        end
        P_ARG2: begin
          do_start  = 1'b1;
          start_len = {1'b0, io_wdata, arg_lo} + 17'd1;
        end
        default: begin end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || soft_rst) begin
      pstate <= P_CMD;
      op     <= '0;
      arg_lo <= '0;
    end else if (wr_cmd) begin
      case (pstate)
        P_CMD: begin
          if (io_wdata inside {OP_DAC, OP_DMA8, OP_TC}) begin
            op     <= io_wdata;
            pstate <= P_ARG1;
          end
        end
        P_ARG1: begin
          if (op == OP_DMA8) begin
            arg_lo <= io_wdata;
            pstate <= P_ARG2;
          end else begin
            pstate <= P_CMD;
          end
        end
        default: pstate <= P_CMD;
      endcase
    end
  end

  // Output queue: pop happens before pushes so a read and a push in one cycle both land.
  always_comb begin
    q0_nxt  = q_mem[0];
    q1_nxt  = q_mem[1];
    cnt_nxt = q_cnt;
    if (soft_rst) begin
      q0_nxt  = RESET_ACK;
      cnt_nxt = 2'd1;
    end else begin
      if (rd_data && q_cnt != 2'd0) begin
        q0_nxt  = q_mem[1];
        cnt_nxt = q_cnt - 2'd1;
      end
      if (do_ver) begin
        if (cnt_nxt == 2'd0) begin
          q0_nxt  = VER_MAJOR;
          q1_nxt  = VER_MINOR;
          cnt_nxt = 2'd2;
        end else if (cnt_nxt == 2'd1) begin
          q1_nxt  = VER_MAJOR;
          cnt_nxt = 2'd2;
        end
      end
    end
  end

  // NOTE: queue storage has no reset; only the occupancy count defines validity.
  always_ff @(posedge clk) begin
    q_mem[0] <= q0_nxt;
    q_mem[1] <= q1_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) q_cnt <= 2'd0;
    else        q_cnt <= cnt_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      io_rdata <= 8'h00;
      io_rhit  <= 1'b0;
    end else if (io_rd) begin
      case (io_addr)
        ADDR_READ: begin
          io_rdata <= (q_cnt != 2'd0) ? q_mem[0] : RESET_ACK;
          io_rhit  <= 1'b1;
        end
        ADDR_STAT: begin
          io_rdata <= {q_cnt != 2'd0, 7'h7F};
          io_rhit  <= 1'b1;
        end
        ADDR_CMD: begin
          io_rdata <= 8'h00;
          io_rhit  <= 1'b1;
        end
        default: io_rhit <= 1'b0;
      endcase
    end
  end

  // DMA pacing FSM. A status read clears irq first so a same-edge set still wins.
  always_ff @(posedge clk) begin
    if (!rst_n || soft_rst) begin
      dstate    <= D_IDLE;
      drq       <= 1'b0;
      irq       <= 1'b0;
      remaining <= '0;
      counter   <= '0;
    end else begin
      if (rd_stat) irq <= 1'b0;
      if (do_start) begin
        remaining <= start_len;
        counter   <= '0;
        drq       <= 1'b0;
        dstate    <= D_WAIT;
      end else begin
        case (dstate)
          D_WAIT: begin
            if (do_pause) begin
              drq    <= 1'b0;
              dstate <= D_PAUSE;
            end else if (counter >= period_m1) begin
              if (dack_s) begin
                drq    <= 1'b1;
                dstate <= D_REQ;
              end
            end else begin
              counter <= counter + 16'd1;
            end
          end
          D_REQ: begin
            if (accept) begin
              drq       <= 1'b0;
              counter   <= '0;
              remaining <= remaining - 17'd1;
              if (remaining == 17'd1) begin
                irq    <= 1'b1;
                dstate <= D_IDLE;
              end else begin
                dstate <= do_pause ? D_PAUSE : D_WAIT;
              end
            end else if (do_pause) begin
              drq    <= 1'b0;
              dstate <= D_PAUSE;
            end
          end
          D_PAUSE: begin
            if (do_resume) begin
              counter <= '0;
              dstate  <= D_WAIT;
            end
          end
          default: dstate <= D_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sample  <= 8'h80;
      pcm_stb <= 1'b0;
      speaker <= 1'b0;
      tc      <= TC_RESET;
      rst_arm <= 1'b0;
    end else begin
      pcm_stb <= accept || do_dac;
      if (accept)      sample <= dma_data;
      else if (do_dac) sample <= io_wdata;
      if (wr_rst) rst_arm <= io_wdata[0];
      if (soft_rst)        speaker <= 1'b0;
      else if (do_spk_on)  speaker <= 1'b1;
      else if (do_spk_off) speaker <= 1'b0;
      if (do_tc) tc <= io_wdata;
    end
  end

  // Flipping the MSB turns offset-binary into two's complement, i.e. byte-128.
  assign pcm_s16 = speaker ? {~sample[7], sample[6:0], 8'h00} : 16'h0000;

endmodule

// File: tb/tb_sb_dsp_dma.sv
// Scoreboard bench for sb_dsp_dma: a behavioural DSP model predicts read bytes,
// PCM samples and DRQ pacing; monitors compare whenever the DUT presents output.
`timescale 1ns/1ps
module tb_sb_dsp_dma;
  localparam int CLKS = 50;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        io_wr = 1'b0, io_rd = 1'b0;
  logic [9:0]  io_addr = '0;
  logic [7:0]  io_wdata = '0;
  logic [7:0]  io_rdata;
  logic        io_rhit;
  logic        dack_n = 1'b1, dma_wr = 1'b0;
  logic [7:0]  dma_data = '0;
  logic        drq, irq, pcm_stb;
  logic [15:0] pcm_s16;

  sb_dsp_dma #(.CLKS_PER_US(CLKS), .TC_RESET(8'hA6)) dut (
    .clk(clk), .rst_n(rst_n), .io_wr(io_wr), .io_rd(io_rd), .io_addr(io_addr),
    .io_wdata(io_wdata), .io_rdata(io_rdata), .io_rhit(io_rhit), .dack_n(dack_n),
    .dma_wr(dma_wr), .dma_data(dma_data), .drq(drq), .irq(irq),
    .pcm_s16(pcm_s16), .pcm_stb(pcm_stb)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_errors = 0, cyc = 0, stb_count = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [7:0] data; logic [7:0] mask; logic hit; } rd_exp_t;
  rd_exp_t     rd_exp[$];
  logic [15:0] pcm_exp[$];

  // Behavioural model of the DSP as seen from the ISA side.
  logic [7:0] m_q[$];
  bit         m_speaker;
  int         m_period, m_remaining;
  logic [7:0] m_last_rdata;
  logic [7:0] data_q[$];
  int         t_ref, last_wr_cyc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] pcm_val(input logic [7:0] b, input bit spk);
    int v;
    v = (int'(b) - 128) * 256;
    return spk ? v[15:0] : 16'h0000;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic io_write(input logic [9:0] a, input logic [7:0] d);
    io_addr = a; io_wdata = d; io_wr = 1'b1;
    tick();
    last_wr_cyc = cyc;
    io_wr = 1'b0;
    tick();
  endtask

  task automatic dsp_cmd(input logic [7:0] d);
    io_write(10'h22C, d);
  endtask

  task automatic io_read(input logic [9:0] a);
    rd_exp_t e;
    case (a)
      10'h22A: begin e.data = (m_q.size() != 0) ? m_q.pop_front() : 8'hAA; e.mask = 8'hFF; e.hit = 1'b1; end
      10'h22E: begin
        e.data = {m_q.size() != 0, 7'h7F};
        e.mask = (m_q.size() != 0) ? 8'h80 : 8'hFF;
        e.hit  = 1'b1;
      end
      10'h22C: begin e.data = 8'h00; e.mask = 8'hFF; e.hit = 1'b1; end
      default: begin e.data = m_last_rdata; e.mask = 8'hFF; e.hit = 1'b0; end
    endcase
    if (e.hit) m_last_rdata = e.data;
    rd_exp.push_back(e);
    io_addr = a; io_rd = 1'b1;
    tick();
    io_rd = 1'b0;
    tick();
  endtask

  task automatic soft_reset();
    io_write(10'h226, 8'h01);
    io_write(10'h226, 8'h00);
    m_q.delete(); m_q.push_back(8'hAA);
    m_speaker = 0; m_remaining = 0;
  endtask

  task automatic version();
    dsp_cmd(8'hE1);
    if (m_q.size() < 2) m_q.push_back(8'h02);
    if (m_q.size() < 2) m_q.push_back(8'h01);
  endtask

  task automatic speaker(input bit on);
    dsp_cmd(on ? 8'hD1 : 8'hD3);
    m_speaker = on;
  endtask

  task automatic set_tc(input logic [7:0] t);
    dsp_cmd(8'h40); dsp_cmd(t);
    m_period = CLKS * (256 - int'(t));
  endtask

  task automatic dac(input logic [7:0] b);
    dsp_cmd(8'h10);
    pcm_exp.push_back(pcm_val(b, m_speaker));
    dsp_cmd(b);
  endtask

  task automatic start_dma(input int len);
    int l1;
    l1 = len - 1;
    dsp_cmd(8'h14); dsp_cmd(l1[7:0]); dsp_cmd(l1[15:8]);
    t_ref = last_wr_cyc;
    m_remaining = len;
  endtask

  task automatic wait_drq(input int limit, output bit ok);
    int w = 0;
    while (drq !== 1'b1 && w < limit) begin tick(); w++; end
    ok = (drq === 1'b1);
    if (!ok) check("drq_timeout", drq, 1'b1);
  endtask

  task automatic serve(input int n, input bit chk_first);
    bit ok;
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      wait_drq(m_period + 200, ok);
      if (!ok) return;
      if (i > 0 || chk_first) check("drq_interval", cyc - t_ref, m_period);
      b = (data_q.size() != 0) ? data_q.pop_front() : 8'($urandom);
      dack_n = 1'b0;
      repeat ($urandom_range(3, 6)) tick();
      pcm_exp.push_back(pcm_val(b, m_speaker));
      m_remaining--;
      dma_wr = 1'b1; dma_data = b;
      tick();
      t_ref = cyc;
      dma_wr = 1'b0; dack_n = 1'b1;
      check("drq_fall", drq, 1'b0);
      check("irq_after_byte", irq, m_remaining == 0);
    end
  endtask

  task automatic count_drq(input int n, input string name);
    int hi = 0;
    repeat (n) begin tick(); if (drq === 1'b1) hi++; end
    check(name, hi, 0);
  endtask

  task automatic ack_irq();
    check("irq_before_ack", irq, 1'b1);
    io_read(10'h22E);
    check("irq_after_ack", irq, 1'b0);
  endtask

  // Read-response monitor: compares the cycle after each io_rd.
  logic rd_d = 1'b0;
  always @(posedge clk) rd_d <= io_rd;
  always @(negedge clk) begin
    if (rd_d) begin
      if (rd_exp.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL rd_unexpected: got %0h with no expected read", io_rdata);
      end else begin
        rd_exp_t e;
        e = rd_exp.pop_front();
        check("rd_hit", io_rhit, e.hit);
        check("rd_data", io_rdata & e.mask, e.data & e.mask);
      end
    end
  end

  // Sample monitor: every pcm_stb must match the next predicted sample.
  always @(negedge clk) begin
    if (pcm_stb === 1'b1) begin
      stb_count++;
      if (pcm_exp.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL pcm_unexpected: got %0h with no expected sample", pcm_s16);
      end else begin
        check("pcm_s16", pcm_s16, pcm_exp.pop_front());
      end
    end
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int c0, stb_before, len;
    m_period = CLKS * (256 - 8'hA6);
    m_last_rdata = 8'h00;
    repeat (3) tick();
    check("rst_drq", drq, 1'b0);
    check("rst_irq", irq, 1'b0);
    check("rst_rdata", io_rdata, 8'h00);
    check("rst_rhit", io_rhit, 1'b0);
    check("rst_pcm", pcm_s16, 16'h0000);
    check("rst_stb", pcm_stb, 1'b0);
    rst_n = 1'b1;
    tick();

    // Detect sequence
    soft_reset();
    io_read(10'h22E);
    io_read(10'h22A);
    io_read(10'h22E);

    // Version, overflow, and version behind a pending AAh
    version();
    io_read(10'h22A); io_read(10'h22A); io_read(10'h22A);
    version(); version();
    io_read(10'h22A); io_read(10'h22A); io_read(10'h22A);
    soft_reset();
    version();
    io_read(10'h22A); io_read(10'h22A); io_read(10'h22A);
    io_read(10'h22C);
    io_read(10'h22A);
    io_read(10'h220);
    dsp_cmd(8'h77);
    io_read(10'h22A);

    // Direct DAC with speaker on and off
    speaker(1); dac(8'h20); dac(8'hFF);
    speaker(0); dac(8'hC0);
    speaker(1);

    // DMA pacing with fixed bytes
    set_tc(8'h9C);
    data_q = '{8'h80, 8'hFF, 8'h00, 8'h40};
    start_dma(4);
    serve(4, 1);
    ack_irq();
    count_drq(6000, "no_drq_after_done");

    // Pause / resume
    set_tc(8'hFB);
    start_dma(10);
    serve(3, 1);
    dsp_cmd(8'hD0);
    check("drq_paused", drq, 1'b0);
    count_drq(20000, "no_drq_while_paused");
    dsp_cmd(8'hD4);
    t_ref = last_wr_cyc;
    serve(7, 1);
    ack_irq();

    // Length using the high byte
    set_tc(8'hFF);
    start_dma(257);
    serve(257, 1);
    ack_irq();

    // Randomized transfers
    repeat (3) begin
      set_tc(8'($urandom_range(240, 254)));
      speaker($urandom_range(0, 1) == 1);
      len = $urandom_range(1, 5);
      start_dma(len);
      serve(len, 1);
      ack_irq();
    end

    // dma_wr without drq is ignored
    stb_before = stb_count;
    dack_n = 1'b0; repeat (3) tick();
    dma_wr = 1'b1; dma_data = 8'h55; tick(); dma_wr = 1'b0;
    dack_n = 1'b1; repeat (3) tick();
    check("no_stb_without_drq", stb_count, stb_before);

    // DACK held low delays drq until dack_s returns high
    set_tc(8'hFB);
    dack_n = 1'b0; tick();
    start_dma(1);
    count_drq(m_period + 100, "drq_held_by_dack");
    dack_n = 1'b1;
    c0 = cyc;
    wait_drq(20, ok);
    if (ok) check("drq_after_dack_release", cyc - c0, 3);
    serve(1, 0);
    ack_irq();

    // Hard reset in the middle of a transfer
    speaker(1);
    start_dma(4);
    serve(1, 1);
    wait_drq(m_period + 200, ok);
    rst_n = 1'b0;
    tick();
    check("midrst_drq", drq, 1'b0);
    check("midrst_irq", irq, 1'b0);
    check("midrst_pcm", pcm_s16, 16'h0000);
    tick();
    rst_n = 1'b1;
    m_q.delete(); m_speaker = 0; m_remaining = 0; m_last_rdata = 8'h00;
    m_period = CLKS * (256 - 8'hA6);
    tick();
    count_drq(400, "no_drq_after_reset");
    io_read(10'h22A);

    repeat (4) tick();
    check("rd_queue_drained", rd_exp.size(), 0);
    check("pcm_queue_drained", pcm_exp.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
